// File: rtl/constants_pkg.sv
// -----------------------------------------------------------------------------
// constants_pkg
// Shared constants for the ALU and its command sequencer.
//   op_e    : 2-bit ALU operation encoding (ADD/SUB/OR/AND), driven on sel_i.
//   state_e : alu_sequencer FSM states (IDLE/EXEC/RESP).
// -----------------------------------------------------------------------------
package constants_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        OR  = 2'b10,
        AND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU shared behind alu_sequencer. Arithmetic wraps
// modulo 2^DWIDTH; there is no carry or overflow output.
// Ports:
//   sel_i  [1:0]        operation (constants_pkg::op_e)
//   op1_i  [DWIDTH-1:0] first operand
//   op2_i  [DWIDTH-1:0] second operand
//   res_o  [DWIDTH-1:0] result
//   zero_o              result is zero
//   neg_o               result MSB (two's-complement sign)
// -----------------------------------------------------------------------------
module alu
    import constants_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic [1:0]        sel_i,
    input  logic [DWIDTH-1:0] op1_i,
    input  logic [DWIDTH-1:0] op2_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              zero_o,
    output logic              neg_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (latch).
        res_o = '0;
        unique case (op_e'(sel_i))
            ADD: res_o = op1_i + op2_i;
            SUB: res_o = op1_i - op2_i;
            OR:  res_o = op1_i | op2_i;
            AND: res_o = op1_i & op2_i;
            default: res_o = '0;
        endcase
    end

    assign zero_o = (res_o == '0);
    assign neg_o  = res_o[DWIDTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Command-side controller for an external, shared combinational alu.
// Accepts a command (IDLE), presents the registered operands to the ALU for
// one cycle (EXEC), captures result/flags into output registers and the
// accumulator, then holds the result until the consumer takes it (RESP).
//
// Configuration macro: ALU_SEQ_OPCOUNT_EN
//   defined   -> 16-bit completed-operation counter on op_count_o
//   undefined -> no counter, no op_count_o port
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), synchronous active-low reset
//   op_valid_i / op_ready_o  command handshake
//   op_sel_i, op_a_i, op_b_i operation and operands
//   op_acc_i                 use accumulator instead of op_a_i
//   acc_clr_i                synchronous accumulator clear (any state)
//   alu_sel_o/op1_o/op2_o    to alu sel_i/op1_i/op2_i
//   alu_res_i/zero_i/neg_i   from alu res_o/zero_o/neg_o
//   res_valid_o/res_ready_i  result handshake
//   res_o, zero_o, neg_o     registered result and flags
//   acc_o                    accumulator
//   op_count_o               completed operations (ALU_SEQ_OPCOUNT_EN only)
// -----------------------------------------------------------------------------
module alu_sequencer
    import constants_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [1:0]        op_sel_i,
    input  logic [DWIDTH-1:0] op_a_i,
    input  logic [DWIDTH-1:0] op_b_i,
    input  logic              op_acc_i,
    input  logic              acc_clr_i,

    output logic [1:0]        alu_sel_o,
    output logic [DWIDTH-1:0] alu_op1_o,
    output logic [DWIDTH-1:0] alu_op2_o,
    input  logic [DWIDTH-1:0] alu_res_i,
    input  logic              alu_zero_i,
    input  logic              alu_neg_i,

    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DWIDTH-1:0] res_o,
    output logic              zero_o,
    output logic              neg_o,
    output logic [DWIDTH-1:0] acc_o
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]       op_count_o
`endif
);

    state_e            state_q;
    state_e            state_d;

    op_e               sel_q;
    logic [DWIDTH-1:0] op1_q;
    logic [DWIDTH-1:0] op2_q;
    logic [DWIDTH-1:0] res_q;
    logic              zero_q;
    logic              neg_q;
    logic [DWIDTH-1:0] acc_q;

    logic              accept;
    logic              capture;

    assign accept  = (state_q == IDLE) && op_valid_i;
    assign capture = (state_q == EXEC);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values of the others.
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (op_valid_i)  state_d = EXEC;
            EXEC:                     state_d = RESP;
            RESP:    if (res_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from state only, never from inputs.
    assign op_ready_o  = (state_q == IDLE);
    assign res_valid_o = (state_q == RESP);

    // -------------------------------------------------------------------------
    // Operand, result and accumulator registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: reset clears every datapath register, so a reset during
        // EXEC/RESP discards the in-flight operation completely.
        if (!rst_ni) begin
            sel_q  <= ADD;
            op1_q  <= '0;
            op2_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            acc_q  <= '0;
        end else begin
            if (accept) begin
                sel_q <= op_e'(op_sel_i);
                // acc_q here is the pre-edge value, so a coinciding clear
                // does not affect the operand.
                op1_q <= op_acc_i ? acc_q : op_a_i;
                op2_q <= op_b_i;
            end
            if (capture) begin
                res_q  <= alu_res_i;
                zero_q <= alu_zero_i;
                neg_q  <= alu_neg_i;
                acc_q  <= alu_res_i;
            end
            // Last assignment wins: a clear overrides the EXEC capture of acc.
            if (acc_clr_i) begin
                acc_q <= '0;
            end
        end
    end

    assign alu_sel_o = sel_q;
    assign alu_op1_o = op1_q;
    assign alu_op2_o = op2_q;
    assign res_o     = res_q;
    assign zero_o    = zero_q;
    assign neg_o     = neg_q;
    assign acc_o     = acc_q;

`ifdef ALU_SEQ_OPCOUNT_EN
    // -------------------------------------------------------------------------
    // Completed-operation counter; wraps naturally at 16 bits and ignores
    // the accumulator clear.
    // -------------------------------------------------------------------------
    logic [15:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (capture) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign op_count_o = count_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed self-checking bench for alu_sequencer connected to alu (DWIDTH=8).
// Honors ALU_SEQ_OPCOUNT_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
    import constants_pkg::*;

    localparam int DWIDTH = 8;

    logic              clk;
    logic              rst_ni;
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_sel;
    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b;
    logic              op_acc;
    logic              acc_clr;
    logic [1:0]        alu_sel;
    logic [DWIDTH-1:0] alu_op1;
    logic [DWIDTH-1:0] alu_op2;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_zero;
    logic              alu_neg;
    logic              res_valid;
    logic              res_ready;
    logic [DWIDTH-1:0] res;
    logic              zero;
    logic              neg;
    logic [DWIDTH-1:0] acc;
`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0]       op_count;
`endif

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.DWIDTH(DWIDTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .op_sel_i    (op_sel),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .op_acc_i    (op_acc),
        .acc_clr_i   (acc_clr),
        .alu_sel_o   (alu_sel),
        .alu_op1_o   (alu_op1),
        .alu_op2_o   (alu_op2),
        .alu_res_i   (alu_res),
        .alu_zero_i  (alu_zero),
        .alu_neg_i   (alu_neg),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_o       (res),
        .zero_o      (zero),
        .neg_o       (neg),
        .acc_o       (acc)
`ifdef ALU_SEQ_OPCOUNT_EN
        ,
        .op_count_o  (op_count)
`endif
    );

    alu #(.DWIDTH(DWIDTH)) u_alu (
        .sel_i  (alu_sel),
        .op1_i  (alu_op1),
        .op2_i  (alu_op2),
        .res_o  (alu_res),
        .zero_o (alu_zero),
        .neg_o  (alu_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Step one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full command/result transaction with immediate consumer acceptance.
    // clr_accept asserts acc_clr on the accept edge, clr_exec on the EXEC edge.
    task automatic run_op(input string tag, input logic [1:0] sel,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input logic clr_accept,
                          input logic clr_exec, input logic [7:0] e_op1,
                          input logic [7:0] e_acc_exec, input logic [7:0] e_res,
                          input logic e_zero, input logic e_neg,
                          input logic [7:0] e_acc);
        check({tag, "_ready_idle"}, op_ready, 1);
        op_valid = 1'b1;
        op_sel   = sel;
        op_a     = a;
        op_b     = b;
        op_acc   = use_acc;
        acc_clr  = clr_accept;
        tick();
        // EXEC cycle
        op_valid = 1'b0;
        op_acc   = 1'b0;
        acc_clr  = clr_exec;
        check({tag, "_ready_exec"}, op_ready, 0);
        check({tag, "_valid_exec"}, res_valid, 0);
        check({tag, "_alu_sel"}, alu_sel, sel);
        check({tag, "_alu_op1"}, alu_op1, e_op1);
        check({tag, "_alu_op2"}, alu_op2, b);
        check({tag, "_acc_exec"}, acc, e_acc_exec);
        tick();
        // RESP cycle
        acc_clr = 1'b0;
        check({tag, "_valid_resp"}, res_valid, 1);
        check({tag, "_ready_resp"}, op_ready, 0);
        check({tag, "_res"}, res, e_res);
        check({tag, "_zero"}, zero, e_zero);
        check({tag, "_neg"}, neg, e_neg);
        check({tag, "_acc"}, acc, e_acc);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_valid_after"}, res_valid, 0);
        check({tag, "_res_hold"}, res, e_res);
    endtask

    initial begin
        rst_ni    = 1'b0;
        op_valid  = 1'b0;
        op_sel    = 2'b00;
        op_a      = '0;
        op_b      = '0;
        op_acc    = 1'b0;
        acc_clr   = 1'b0;
        res_ready = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        rst_ni = 1'b1;
        check("rst_ready", op_ready, 1);
        check("rst_valid", res_valid, 0);
        check("rst_res", res, 0);
        check("rst_zero", zero, 0);
        check("rst_neg", neg, 0);
        check("rst_acc", acc, 0);
        check("rst_alu_sel", alu_sel, ADD);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_op2", alu_op2, 0);
`ifdef ALU_SEQ_OPCOUNT_EN
        check("rst_count", op_count, 0);
`endif

        // ---------------- basic ops and accumulator chain ----------------
        //     tag       sel  a      b      acc clrA clrE op1    accE   res    z  n  acc
        run_op("add",    ADD, 8'h05, 8'h03, 0,  0,   0,   8'h05, 8'h00, 8'h08, 0, 0, 8'h08);
        run_op("or_acc", OR,  8'hAA, 8'h10, 1,  0,   0,   8'h08, 8'h08, 8'h18, 0, 0, 8'h18);
        run_op("and_acc",AND, 8'hFF, 8'h0F, 1,  0,   0,   8'h18, 8'h18, 8'h08, 0, 0, 8'h08);
        run_op("sub_neg",SUB, 8'h03, 8'h05, 0,  0,   0,   8'h03, 8'h08, 8'hFE, 0, 1, 8'hFE);
        run_op("sub_zero",SUB,8'h07, 8'h07, 0,  0,   0,   8'h07, 8'hFE, 8'h00, 1, 0, 8'h00);
        run_op("add_42", ADD, 8'h40, 8'h02, 0,  0,   0,   8'h40, 8'h00, 8'h42, 0, 0, 8'h42);
        // clear coinciding with accept: op1 takes the pre-clear accumulator
        run_op("clr_acc",OR,  8'h00, 8'h01, 1,  1,   0,   8'h42, 8'h00, 8'h43, 0, 0, 8'h43);
        // clear coinciding with EXEC capture: result captured, acc cleared
        run_op("clr_exe",ADD, 8'h20, 8'h01, 0,  0,   1,   8'h20, 8'h43, 8'h21, 0, 0, 8'h00);

        // ---------------- backpressure ----------------
        op_valid = 1'b1;
        op_sel   = ADD;
        op_a     = 8'h10;
        op_b     = 8'h02;
        tick();                     // accepted -> EXEC
        op_sel = SUB;               // next command presented, valid held high
        op_a   = 8'h09;
        op_b   = 8'h04;
        tick();                     // -> RESP
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", res_valid, 1);
            check("bp_ready", op_ready, 0);
            check("bp_res", res, 8'h12);
            check("bp_flags", {zero, neg}, 2'b00);
            tick();
        end
        check("bp_res_final", res, 8'h12);
        check("bp_op1_hold", alu_op1, 8'h10);
        res_ready = 1'b1;
        tick();                     // handshake -> IDLE
        res_ready = 1'b0;
        check("bp_idle_ready", op_ready, 1);
        check("bp_idle_valid", res_valid, 0);
        tick();                     // second command accepted now
        op_valid = 1'b0;
        check("bp2_exec_ready", op_ready, 0);
        check("bp2_alu_sel", alu_sel, SUB);
        check("bp2_alu_op1", alu_op1, 8'h09);
        check("bp2_alu_op2", alu_op2, 8'h04);
        tick();
        check("bp2_valid", res_valid, 1);
        check("bp2_res", res, 8'h05);
        check("bp2_acc", acc, 8'h05);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
`ifdef ALU_SEQ_OPCOUNT_EN
        check("count_10", op_count, 10);
`endif

        // ---------------- reset during EXEC ----------------
        op_valid = 1'b1;
        op_sel   = ADD;
        op_a     = 8'h11;
        op_b     = 8'h11;
        tick();                     // accepted -> EXEC
        op_valid = 1'b0;
        rst_ni   = 1'b0;
        tick();                     // reset edge
        rst_ni = 1'b1;
        check("mid_rst_ready", op_ready, 1);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_res", res, 0);
        check("mid_rst_flags", {zero, neg}, 2'b00);
        check("mid_rst_acc", acc, 0);
        check("mid_rst_alu_sel", alu_sel, ADD);
        check("mid_rst_alu_op1", alu_op1, 0);
        check("mid_rst_alu_op2", alu_op2, 0);
`ifdef ALU_SEQ_OPCOUNT_EN
        check("mid_rst_count", op_count, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_valid", res_valid, 0);
        end

        // ---------------- post-reset operations ----------------
        run_op("p_add",  ADD, 8'h01, 8'h02, 0,  0,   0,   8'h01, 8'h00, 8'h03, 0, 0, 8'h03);
        run_op("p_sub",  SUB, 8'h00, 8'h03, 1,  0,   0,   8'h03, 8'h03, 8'h00, 1, 0, 8'h00);
        run_op("p_and",  AND, 8'hF0, 8'h3C, 0,  0,   0,   8'hF0, 8'h00, 8'h30, 0, 0, 8'h30);
`ifdef ALU_SEQ_OPCOUNT_EN
        check("count_3", op_count, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side controller for the combinational `alu`. It accepts operation requests over a valid/ready handshake and registers the operands. It drives the ALU's `sel_i`/`op1_i`/`op2_i` inputs for one cycle and captures the ALU's `res_o`/`zero_o`/`neg_o` outputs. It then returns the result over a second valid/ready handshake, keeping an accumulator so operations can be chained; it sits between the datapath control and a shared ALU instance.

## Interface
- `DWIDTH`, default 8: operand, result and accumulator width; must match the connected `alu`.
- `clk_i`  in  1: clock, rising edge.
- `rst_ni`  in  1: reset; synchronous, active-low.
- `op_valid_i`  in  1: command valid.
- `op_ready_o`  out  1: sequencer can accept a command.
- `op_sel_i`  in  2: operation; constants_pkg encoding ADD/SUB/OR/AND.
- `op_a_i`  in  DWIDTH: first operand; ignored when `op_acc_i`=1.
- `op_b_i`  in  DWIDTH: second operand.
- `op_acc_i`  in  1: use the accumulator as the first operand.
- `acc_clr_i`  in  1: synchronous accumulator clear; accepted in any state.
- `alu_sel_o`  out  2: to alu `sel_i`.
- `alu_op1_o`  out  DWIDTH: to alu `op1_i`.
- `alu_op2_o`  out  DWIDTH: to alu `op2_i`.
- `alu_res_i`  in  DWIDTH: from alu `res_o`.
- `alu_zero_i`  in  1: from alu `zero_o`.
- `alu_neg_i`  in  1: from alu `neg_o`.
- `res_valid_o`  out  1: result valid.
- `res_ready_i`  in  1: consumer accepts the result.
- `res_o`  out  DWIDTH: registered result.
- `zero_o`  out  1: registered zero flag.
- `neg_o`  out  1: registered negative flag.
- `acc_o`  out  DWIDTH: current accumulator value.
- `op_count_o`  out  16: completed-operation count; present only with `ALU_SEQ_OPCOUNT_EN`.

## Operation
- FSM states are IDLE, EXEC and RESP; the reset state is IDLE.
- **IDLE**
  - `op_ready_o`=1.
  - When `op_valid_i`=1, the command is accepted at that edge:
    - the sel register loads `op_sel_i`;
    - the op1 register loads `acc` if `op_acc_i`=1, otherwise `op_a_i`;
    - the op2 register loads `op_b_i`;
    - the FSM goes to EXEC.
- **EXEC**
  - Lasts exactly one cycle; `op_ready_o`=0.
  - The ALU sees the registered operands.
  - At the end of the cycle, `res_o`/`zero_o`/`neg_o` capture `alu_res_i`/`alu_zero_i`/`alu_neg_i`.
  - `acc` loads `alu_res_i`.
  - The FSM goes to RESP.
- **RESP**
  - `res_valid_o`=1 and `op_ready_o`=0.
  - The FSM returns to IDLE at the edge where `res_ready_i`=1.
  - Results and flags stay stable until the next EXEC.
- `alu_sel_o`/`alu_op1_o`/`alu_op2_o` always reflect the operand registers, so they stay stable outside EXEC.
- The flags come from the ALU and are not recomputed locally. Arithmetic wraps modulo 2^DWIDTH, with no carry or overflow output.
- `acc_clr_i`:
  - clears `acc` to 0 at the next edge in any state;
  - if it coincides with the EXEC capture, the clear wins and `acc`=0, but `res_o` still captures the ALU result;
  - if it coincides with an IDLE accept with `op_acc_i`=1, op1 loads the pre-clear `acc`.
- While `op_ready_o`=0, `op_valid_i` is ignored and no command is queued.

## Timing
- Accept at edge N; EXEC is the cycle N to N+1; `res_valid_o`=1 from edge N+1.
- The earliest next accept is the cycle after the result handshake, giving at most one operation every 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Reset values:
  - FSM in IDLE, so `op_ready_o`=1 and `res_valid_o`=0;
  - `res_o`, `zero_o`, `neg_o`, `acc_o` and the operand registers = 0;
  - `alu_sel_o` = ADD;
  - `op_count_o` = 0.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. The in-flight result is discarded and all registers take their reset values at that edge.

## Configuration
- `ALU_SEQ_OPCOUNT_EN` defined:
  - a 16-bit counter increments at every EXEC capture and wraps 0xFFFF to 0x0000;
  - `acc_clr_i` does not affect it;
  - it is exposed on `op_count_o`.
- Not defined: neither the counter nor the `op_count_o` port exists; all other behaviour is identical.

## Structure
- Operation encodings (ADD/SUB/OR/AND) come from the shared constants_pkg. The FSM state enum (IDLE/EXEC/RESP) is added to constants_pkg as well.
- There are no sub-modules. The `alu` stays external so the top level can share one instance; the bench instantiates `alu` with `DWIDTH`=8 and connects it to the `alu_*` ports.

## Test plan
- **Basic ADD:** reset, then ADD a=5 b=3 → `res_valid_o` one cycle after accept; `res_o`=0x08, `zero_o`=0, `neg_o`=0, `acc_o`=0x08.
- **Negative result:** SUB a=3 b=5 → `res_o`=0xFE, `neg_o`=1. Then SUB a=7 b=7 → `res_o`=0x00, `zero_o`=1.
- **Accumulator chain:** ADD 5+3, then OR with `op_acc_i`=1 and b=0x10 → `res_o`=0x18 and `acc_o`=0x18. Then AND with acc and b=0x0F → `res_o`=0x08.
- **Backpressure:** hold `res_ready_i`=0 for 4 cycles with `op_valid_i`=1 throughout:
  - `res_o` and the flags stay stable and `op_ready_o`=0;
  - the second command is accepted only in the cycle after `res_ready_i`=1.
- **Clear collision:** assert `acc_clr_i` during EXEC of ADD 0x20+0x01 → `res_o`=0x21 and `acc_o`=0x00.
- **Reset mid-operation:** assert `rst_ni`=0 during EXEC → all outputs at reset values at the next edge and `res_valid_o` never asserts. With `ALU_SEQ_OPCOUNT_EN` defined, `op_count_o` counts only completed operations (3 operations → 3).
